// File: rtl/sle_dbnc_pkg.sv
// Shared types and defaults for the SLE Q-output debouncer.
package sle_dbnc_pkg;

    // Qualifier FSM: two stable levels, each with a check state towards the other.
    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } dbnc_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CNT_DEF  = 4;

endpackage

// File: rtl/sle_sync_chain.sv
// Plain flop-chain synchroniser; Q is the last stage.
module sle_sync_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] stage_in;

    // Each stage takes the raw input (first stage) or the previous stage.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_in[gi] = D;
        end else begin : g_next
            assign stage_in[gi] = sync_reg[gi-1];
        end
    end

    // Shift every cycle; reset preloads every stage with the reset level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= stage_in;
        end
    end

    assign Q = sync_reg[STAGES-1];

endmodule

// File: rtl/sle_q_debounce.sv
// Debouncer for the SLE Q output: synchronise, then accept a level change
// only after it has held for STABLE_CNT consecutive enabled cycles.
module sle_q_debounce
    import sle_dbnc_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   STABLE_CNT  = STABLE_CNT_DEF,
    parameter int   CNT_W       = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic Q_IN,
    output logic Q_OUT,
    output logic RISE,
    output logic FALL,
    output logic GLITCH,
    output logic BUSY
);

    // Reject illegal parameterisations at elaboration.
    if (STABLE_CNT < 2) begin : g_bad_cnt_lo
        $fatal(1, "sle_q_debounce: STABLE_CNT must be at least 2");
    end
    if (64'(STABLE_CNT) > ((64'(1) << CNT_W) - 64'(1))) begin : g_bad_cnt_hi
        $fatal(1, "sle_q_debounce: STABLE_CNT does not fit in CNT_W bits");
    end
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
        $fatal(1, "sle_q_debounce: SYNC_STAGES must be 2..4");
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam dbnc_state_t      ST_RST   = RST_VAL ? ST_HI : ST_LO;

    logic             s;
    dbnc_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             q_out_reg, q_out_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;
    logic             glitch_reg, glitch_next;

    sle_sync_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (Q_IN),
        .Q   (s)
    );

    // State, counter and registered outputs; reset aborts any check silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_RST;
            cnt_reg    <= '0;
            q_out_reg  <= RST_VAL;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
            glitch_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            q_out_reg  <= q_out_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            glitch_reg <= glitch_next;
        end
    end

    // Next-state logic; EN=0 holds everything and suppresses strobes.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        q_out_next  = q_out_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        glitch_next = 1'b0;
        if (EN) begin
            case (state_reg)
                ST_LO: begin
                    if (s) begin
                        state_next = CHK_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state_next  = ST_LO;
                        cnt_next    = '0;
                        glitch_next = 1'b1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = ST_HI;
                        cnt_next   = '0;
                        q_out_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state_next = CHK_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state_next  = ST_HI;
                        cnt_next    = '0;
                        glitch_next = 1'b1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = ST_LO;
                        cnt_next   = '0;
                        q_out_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_RST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign Q_OUT  = q_out_reg;
    assign RISE   = rise_reg;
    assign FALL   = fall_reg;
    assign GLITCH = glitch_reg;
    assign BUSY   = (state_reg == CHK_HI) || (state_reg == CHK_LO);

endmodule

// File: tb/tb_sle_q_debounce.sv
// Directed bench for sle_q_debounce at default parameters.
module tb_sle_q_debounce;
    import sle_dbnc_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic EN;
    logic Q_IN;
    logic Q_OUT;
    logic RISE;
    logic FALL;
    logic GLITCH;
    logic BUSY;

    int checks = 0;
    int errors = 0;

    sle_q_debounce dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .Q_IN   (Q_IN),
        .Q_OUT  (Q_OUT),
        .RISE   (RISE),
        .FALL   (FALL),
        .GLITCH (GLITCH),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    // Advance one rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all visible outputs at once.
    task automatic chk_all(input string tag, input logic q, input logic r,
                           input logic f, input logic g, input logic b);
        chk({tag, ".q_out"},  32'(Q_OUT),  32'(q));
        chk({tag, ".rise"},   32'(RISE),   32'(r));
        chk({tag, ".fall"},   32'(FALL),   32'(f));
        chk({tag, ".glitch"}, 32'(GLITCH), 32'(g));
        chk({tag, ".busy"},   32'(BUSY),   32'(b));
    endtask

    initial begin
        RST  = 1'b1;
        EN   = 1'b1;
        Q_IN = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", 32'(dut.state_reg), 32'(ST_LO));
        chk("reset.cnt",   32'(dut.cnt_reg),   32'd0);
        $display("reset: q_out=%0b busy=%0b", Q_OUT, BUSY);

        // Idle with Q_IN low after release.
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        $display("idle: 10 cycles q_out=%0b", Q_OUT);

        // Clean rise: accepted at edge k+5.
        Q_IN = 1'b1;
        tick();  chk_all("rise.k0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("rise.k1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("rise.k2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("rise.k3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("rise.k4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("rise.k5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("rise.k6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("rise: q_out=%0b", Q_OUT);

        // Clean fall at k+5, then reset at k+6.
        Q_IN = 1'b0;
        tick();  chk_all("fall.k0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("fall.k1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("fall.k2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("fall.k3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("fall.k4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("fall.k5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        tick();  chk_all("fall.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fall.rst.state", 32'(dut.state_reg), 32'(ST_LO));
        RST = 1'b0;
        tick();  chk_all("fall.post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("fall+reset: q_out=%0b", Q_OUT);

        // Two-cycle pulse: abandoned check gives a single GLITCH.
        Q_IN = 1'b1;
        tick();  chk_all("glitch.k0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("glitch.k1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Q_IN = 1'b0;
        tick();  chk_all("glitch.k2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("glitch.k3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("glitch.k4", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("glitch.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        $display("glitch: q_out=%0b", Q_OUT);

        // Rise with EN low for three edges mid-check: accepted at k+8.
        Q_IN = 1'b1;
        tick();  chk_all("stall.k0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("stall.k1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("stall.k2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stall.k2.cnt", 32'(dut.cnt_reg), 32'd1);
        EN = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            tick();
            chk_all("stall.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("stall.hold.cnt", 32'(dut.cnt_reg), 32'd1);
        end
        EN = 1'b1;
        tick();  chk("stall.k6.cnt", 32'(dut.cnt_reg), 32'd2);
        tick();  chk("stall.k7.cnt", 32'(dut.cnt_reg), 32'd3);
        chk_all("stall.k7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk_all("stall.k8", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("stall.k9", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("stall rise: q_out=%0b", Q_OUT);

        // Return to low via reset.
        Q_IN = 1'b0;
        RST  = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();  chk_all("reinit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid CHK_HI aborts the check with no strobe.
        Q_IN = 1'b1;
        tick();
        tick();
        tick();  chk_all("abort.k2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();  chk("abort.k3.cnt", 32'(dut.cnt_reg), 32'd2);
        RST = 1'b1;
        tick();  chk_all("abort.k4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort.k4.state", 32'(dut.state_reg), 32'(ST_LO));
        chk("abort.k4.cnt",   32'(dut.cnt_reg),   32'd0);
        RST = 1'b0;
        tick();  chk_all("abort.k5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("abort.k6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();  chk_all("abort.k7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("reset abort: q_out=%0b busy=%0b", Q_OUT, BUSY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sle_q_debounce.md
Name: sle_q_debounce

Overview:
- Downstream consumer of the SLE flop output Q.
- Synchronises Q into the CLK domain with a flop chain, then qualifies each level change.
- A change is accepted only after it has been held for STABLE_CNT consecutive enabled cycles.
- Outputs a clean level plus single-cycle RISE, FALL and GLITCH strobes for downstream control logic.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on Q_IN; legal range 2..4.
- STABLE_CNT, 4: consecutive enabled cycles the new level must hold before acceptance; legal range 2..2^CNT_W-1.
- CNT_W, 8: width of the stability counter.
- RST_VAL, 0: level loaded into the sync chain and Q_OUT on reset.

Ports:
- CLK  input  1  rising-edge clock, single clock domain.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  qualify enable; 0 freezes FSM and counter.
- Q_IN  input  1  raw level from the SLE Q output; may be asynchronous to CLK.
- Q_OUT  output  1  debounced level.
- RISE  output  1  one-cycle strobe when Q_OUT goes 0->1.
- FALL  output  1  one-cycle strobe when Q_OUT goes 1->0.
- GLITCH  output  1  one-cycle strobe when a candidate change is abandoned.
- BUSY  output  1  high while in CHK_HI or CHK_LO.

Behaviour:
- Reset (RST=1 at a CLK edge): every sync flop <= RST_VAL; state <= ST_LO if RST_VAL=0, else ST_HI; cnt <= 0; Q_OUT <= RST_VAL; RISE=FALL=GLITCH=BUSY=0.
- Reset mid-check: aborts the check; no RISE, FALL or GLITCH is emitted.
- Sync chain: shifts every cycle except in reset, independent of EN. s = last stage.
- FSM states: ST_LO, CHK_HI, ST_HI, CHK_LO. All outputs are registered.
- ST_LO:
  - EN=1 and s=1 -> CHK_HI, cnt <= 1.
  - Otherwise stay.
- CHK_HI, EN=1:
  - s=0 -> ST_LO, cnt <= 0, GLITCH <= 1.
  - s=1 and cnt=STABLE_CNT-1 -> ST_HI, Q_OUT <= 1, RISE <= 1, cnt <= 0.
  - s=1 otherwise -> cnt <= cnt+1.
- ST_HI and CHK_LO: mirror of ST_LO and CHK_HI with levels swapped; acceptance gives Q_OUT <= 0 and FALL <= 1.
- EN=0 in any state: state, cnt and Q_OUT hold; strobes forced 0; BUSY reflects the held state.
- Latency: let edge k be the first edge at which the first sync flop captures the new level, with Q_IN then held and EN=1. Q_OUT changes, and the strobe fires, on edge k+SYNC_STAGES+STABLE_CNT-1. Defaults: edge k+5.
- EN=0 cycles during a check extend the latency one-for-one.
- Strobes: each is high for exactly one cycle and the three are mutually exclusive. At most one strobe per accepted or abandoned change.
- Counter: cnt never exceeds STABLE_CNT-1 and never wraps.
- Parameter checks: elaboration-time fatal if STABLE_CNT<2, STABLE_CNT>2^CNT_W-1, or SYNC_STAGES outside 2..4.
- Q_IN toggling every cycle: FSM alternates between CHK_x and ST_x, emitting GLITCH; Q_OUT never changes.

Decomposition:
- Package sle_dbnc_pkg holds:
  - state enum {ST_LO, CHK_HI, ST_HI, CHK_LO}, 2-bit encoding;
  - localparam defaults for SYNC_STAGES and STABLE_CNT.
- Sub-module sle_sync_chain (parameters STAGES, RST_VAL; ports CLK, RST, D, Q) implements the synchroniser. The FSM and counter stay in sle_q_debounce.

Test Plan (defaults: SYNC_STAGES=2, STABLE_CNT=4, RST_VAL=0, EN=1 unless stated):
- Reset release with Q_IN=0 for 10 cycles -> Q_OUT=0, BUSY=0, no strobes throughout.
- Q_IN 0->1 captured at edge k and held -> BUSY=1 from edge k+2; Q_OUT=1 and RISE=1 for one cycle at edge k+5.
- Q_IN high for 2 cycles then low -> BUSY pulses, GLITCH=1 exactly once, Q_OUT stays 0, RISE never asserted.
- Q_IN 0->1 held; EN=0 for 3 cycles starting edge k+3 -> Q_OUT=1 and RISE at edge k+8; cnt held during EN=0.
- From Q_OUT=1, Q_IN 1->0 held -> FALL=1 one cycle at edge k+5, Q_OUT=0; then RST=1 at edge k+6 -> Q_OUT=0, state ST_LO, no strobe.
- Q_IN 1 held, RST=1 asserted at edge k+4 mid CHK_HI -> next cycle state ST_LO, cnt=0, Q_OUT=0, no RISE and no GLITCH.
